// File: rtl/demod_sched_pkg.sv
// Shared types and helpers for the demodulator channel scheduler.
package demod_sched_pkg;

  typedef enum logic [2:0] {IDLE, NEXT, FLUSH, SETTLE, CAPTURE, EMIT} sched_state_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_next_channel.sv
// Round-robin picker: lowest set mask bit strictly after cur, wrapping; may return cur itself.
module rr_next_channel
  import demod_sched_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CW     = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CW-1:0]     cur,
  output logic [CW-1:0]     next,
  output logic              found
);

  logic [CW:0] idx;

  // cur + i stays below 2*NUM_CH, so a single conditional subtract wraps it
  always_comb begin
    next  = cur;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = {1'b0, cur} + (CW+1)'(i);
      if (idx >= (CW+1)'(NUM_CH)) idx = idx - (CW+1)'(NUM_CH);
      if (!found && mask[idx[CW-1:0]]) begin
        found = 1'b1;
        next  = idx[CW-1:0];
      end
    end
  end

endmodule

// File: rtl/demod_scheduler.sv
// Shares one quadrature demod datapath across NUM_CH ADC channels: flush, settle,
// capture one decimated result per channel and hand it out on a valid/ready port.
module demod_scheduler
  import demod_sched_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int ADC_RESOLUTION = 12,
  parameter int OUT_RESOLUTION = 14,
  parameter int FLUSH_CYCLES   = 8,
  parameter int SETTLE_DEC     = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [NUM_CH-1:0]                ch_mask,
  input  logic [NUM_CH*ADC_RESOLUTION-1:0] adc_data,
  output logic [ADC_RESOLUTION-1:0]        dp_sample,
  output logic                             dp_flush,
  input  logic                             dp_dec_en,
  input  logic [OUT_RESOLUTION-1:0]        dp_result,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [$clog2(NUM_CH)-1:0]        res_ch,
  output logic [OUT_RESOLUTION-1:0]        res_data,
  output logic                             busy
);

  localparam int CW = ch_width(NUM_CH);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int SW = (SETTLE_DEC > 0) ? $clog2(SETTLE_DEC + 1) : 1;

  sched_state_t              state, state_d;
  logic [CW-1:0]             cur_ch, pick_ch, search_from, sample_ch;
  logic                      pick_found, first_pass, stop_req;
  logic [FW-1:0]             flush_cnt;
  logic [SW-1:0]             settle_cnt;
  logic [OUT_RESOLUTION-1:0] cap_data;
  logic [CW-1:0]             cap_ch;
  logic                      ch_ld, cnt_clr, flush_inc, settle_inc, cap_ld, emit_ld, slot_free;

  // first search after reset starts from the top index so channel 0 wins
  assign search_from = first_pass ? CW'(NUM_CH - 1) : cur_ch;
  assign sample_ch   = ch_ld ? pick_ch : cur_ch;
  assign slot_free   = !res_valid || res_ready;
  assign dp_flush    = (state == FLUSH);
  assign busy        = (state != IDLE);

  rr_next_channel #(.NUM_CH(NUM_CH), .CW(CW)) u_pick (
    .mask  (ch_mask),
    .cur   (search_from),
    .next  (pick_ch),
    .found (pick_found)
  );

  always_comb begin
    state_d    = state;
    ch_ld      = 1'b0;
    cnt_clr    = 1'b0;
    flush_inc  = 1'b0;
    settle_inc = 1'b0;
    cap_ld     = 1'b0;
    emit_ld    = 1'b0;
    unique case (state)
      IDLE: if (enable) state_d = NEXT;
      NEXT: begin
        if (!pick_found) state_d = IDLE;
        else begin
          ch_ld   = 1'b1;
          cnt_clr = 1'b1;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!enable) state_d = IDLE;
        else if (flush_cnt == FW'(FLUSH_CYCLES - 1)) state_d = SETTLE;
        else flush_inc = 1'b1;
      end
      SETTLE: begin
        if (!enable) state_d = IDLE;
        else if (SETTLE_DEC == 0) state_d = CAPTURE;
        else if (dp_dec_en) begin
          if (settle_cnt == SW'(SETTLE_DEC - 1)) state_d = CAPTURE;
          else settle_inc = 1'b1;
        end
      end
      CAPTURE: begin
        if (!enable) state_d = IDLE;
        else if (dp_dec_en) begin
          cap_ld  = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (slot_free) begin
          emit_ld = 1'b1;
          state_d = (enable && !stop_req) ? NEXT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cur_ch     <= '0;
      first_pass <= 1'b1;
      stop_req   <= 1'b0;
      flush_cnt  <= '0;
      settle_cnt <= '0;
      cap_data   <= '0;
      cap_ch     <= '0;
      dp_sample  <= '0;
      res_valid  <= 1'b0;
      res_ch     <= '0;
      res_data   <= '0;
    end else begin
      state     <= state_d;
      dp_sample <= adc_data[int'(sample_ch)*ADC_RESOLUTION +: ADC_RESOLUTION];
      if (ch_ld) begin
        cur_ch     <= pick_ch;
        first_pass <= 1'b0;
      end
      if (cnt_clr) begin
        flush_cnt  <= '0;
        settle_cnt <= '0;
      end else begin
        if (flush_inc)  flush_cnt  <= flush_cnt + FW'(1);
        if (settle_inc) settle_cnt <= settle_cnt + SW'(1);
      end
      // an enable drop while stalled in EMIT is remembered until the emit completes
      if (state != EMIT) stop_req <= 1'b0;
      else if (!enable)  stop_req <= 1'b1;
      if (cap_ld) begin
        cap_data <= dp_result;
        cap_ch   <= cur_ch;
      end
      if (emit_ld) begin
        res_valid <= 1'b1;
        res_data  <= cap_data;
        res_ch    <= cap_ch;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demod_scheduler.sv
// Directed bench for demod_scheduler: round robin, masking, backpressure, enable drops, reset.
module tb_demod_scheduler;
  localparam int NCH = 2, AW = 12, OW = 14, FC = 4, SD = 2;

  logic                clk = 1'b0, reset = 1'b0, enable = 1'b0, res_ready = 1'b0;
  logic                dp_dec_en = 1'b0;
  logic [NCH-1:0]      ch_mask = '0;
  logic [NCH*AW-1:0]   adc_data = {12'h5A5, 12'h123};
  logic [OW-1:0]       dp_result = '0;
  logic [AW-1:0]       dp_sample;
  logic                dp_flush, res_valid, busy;
  logic [0:0]          res_ch;
  logic [OW-1:0]       res_data;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  demod_scheduler #(
    .NUM_CH(NCH), .ADC_RESOLUTION(AW), .OUT_RESOLUTION(OW),
    .FLUSH_CYCLES(FC), .SETTLE_DEC(SD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask), .adc_data(adc_data),
    .dp_sample(dp_sample), .dp_flush(dp_flush), .dp_dec_en(dp_dec_en), .dp_result(dp_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch), .res_data(res_data),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // decimation strobe every 10 cycles, result is a ramp
  int tcnt = 0;
  initial forever begin
    @(negedge clk);
    tcnt++;
    dp_dec_en = (tcnt % 10 == 0);
    dp_result = OW'(tcnt * 7);
  end

  // reference: 3rd strobe after each flush ends is the expected capture
  logic       pv = 1'b0, pflush = 1'b0;
  logic [OW-1:0] pd = '0;
  logic [0:0] pc = '0;
  bit  mon_on = 1'b0, armed = 1'b0;
  int  post = 0, flen = 0, acc_cnt = 0, nflush = 0;
  int  exp_q[$];
  int  ch_q[$];

  initial forever begin
    @(posedge clk);
    #1;
    if (pflush) begin
      armed = 1'b1;
      post  = 0;
    end else if (dp_dec_en && armed) begin
      post++;
      if (post == SD + 1) begin
        if (mon_on) exp_q.push_back(int'(dp_result));
        armed = 1'b0;
      end
    end
    if (dp_flush) flen++;
    else if (pflush) begin
      nflush++;
      if (mon_on) chk("flush_len", flen, FC);
      flen = 0;
    end
    if (pv && res_ready && mon_on) begin
      acc_cnt++;
      chk("result_expected", (exp_q.size() > 0 && ch_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0 && ch_q.size() > 0) begin
        chk("res_data", pd, exp_q.pop_front());
        chk("res_ch", pc, ch_q.pop_front());
      end
    end
    pv = res_valid; pd = res_data; pc = res_ch; pflush = dp_flush;
  end

  task automatic wait_acc(input int n, input int budget);
    for (int i = 0; i < budget && acc_cnt < n; i++) @(negedge clk);
  endtask

  task automatic mon_start();
    exp_q.delete();
    acc_cnt = 0; armed = 1'b0; flen = 0; mon_on = 1'b1;
  endtask

  int f0, idle_n, fl_n, stable, rv;
  logic [OW-1:0] d0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sample", dp_sample, 0);
    chk("rst_flush", dp_flush, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_ch", res_ch, 0);
    chk("rst_data", res_data, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);

    // alternate between both channels
    ch_mask = 2'b11; res_ready = 1'b1;
    ch_q = '{0, 1, 0, 1};
    mon_start();
    enable = 1'b1;
    repeat (2) @(negedge clk);
    chk("s1_flush_rise", dp_flush, 1);
    chk("s1_sample_ch0", dp_sample, 'h123);
    wait_acc(4, 1000);
    chk("s1_acc", acc_cnt, 4);
    mon_on = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("s1_idle", busy, 0);

    // only channel 1 enabled
    ch_mask = 2'b10;
    ch_q = '{1, 1};
    f0 = nflush;
    mon_start();
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("s2_sample_ch1", dp_sample, 'h5A5);
    wait_acc(2, 1000);
    chk("s2_acc", acc_cnt, 2);
    chk("s2_flushes", (nflush - f0 >= 2) ? 1 : 0, 1);
    mon_on = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);

    // empty mask bounces NEXT <-> IDLE without flushing
    ch_mask = '0; idle_n = 0; fl_n = 0;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) idle_n++;
      if (dp_flush) fl_n++;
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("s3_idle_cycles", idle_n, 5);
    chk("s3_no_flush", fl_n, 0);
    chk("s3_busy", busy, 0);

    // backpressure: first result held for 100 cycles
    ch_mask = 2'b11; res_ready = 1'b0;
    ch_q = '{0, 1};
    mon_start();
    enable = 1'b1;
    for (int i = 0; i < 1000 && !res_valid; i++) @(negedge clk);
    chk("s4_valid", res_valid, 1);
    d0 = res_data; stable = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid && res_data == d0) stable++;
    end
    chk("s4_hold", stable, 100);
    chk("s4_busy", busy, 1);
    res_ready = 1'b1;
    @(negedge clk);
    chk("s4_first_acc", acc_cnt, 1);
    chk("s4_second_valid", res_valid, 1);
    chk("s4_second_ch", res_ch, 1);
    wait_acc(2, 50);
    chk("s4_acc", acc_cnt, 2);
    mon_on = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);

    // enable dropped in SETTLE
    ch_mask = 2'b11; res_ready = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 100 && !dp_flush; i++) @(negedge clk);
    for (int i = 0; i < 100 && dp_flush; i++) @(negedge clk);
    chk("s5_in_settle", (busy && !dp_flush) ? 1 : 0, 1);
    enable = 1'b0;
    @(negedge clk);
    chk("s5_idle", busy, 0);
    rv = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (res_valid) rv++;
    end
    chk("s5_no_result", rv, 0);

    // enable dropped while stalled in EMIT
    res_ready = 1'b0;
    ch_q = '{0, 1};
    mon_start();
    enable = 1'b1;
    for (int i = 0; i < 1000 && !res_valid; i++) @(negedge clk);
    chk("s6_valid", res_valid, 1);
    repeat (100) @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("s6_busy_hold", busy, 1);
    res_ready = 1'b1;
    @(negedge clk);
    chk("s6_emit_valid", res_valid, 1);
    chk("s6_emit_ch", res_ch, 1);
    chk("s6_idle", busy, 0);
    @(negedge clk);
    chk("s6_valid_clr", res_valid, 0);
    chk("s6_acc", acc_cnt, 2);
    mon_on = 1'b0;

    // reset while in CAPTURE with a pending result
    res_ready = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 1000 && !res_valid; i++) @(negedge clk);
    for (int i = 0; i < 100 && !dp_flush; i++) @(negedge clk);
    for (int i = 0; i < 200 && !(armed && post == SD && !dp_flush); i++) @(negedge clk);
    chk("s7_pre_valid", res_valid, 1);
    chk("s7_pre_capture", (armed && post == SD && busy) ? 1 : 0, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("s7_rst_sample", dp_sample, 0);
    chk("s7_rst_flush", dp_flush, 0);
    chk("s7_rst_valid", res_valid, 0);
    chk("s7_rst_ch", res_ch, 0);
    chk("s7_rst_data", res_data, 0);
    chk("s7_rst_busy", busy, 0);
    reset = 1'b1; res_ready = 1'b1;
    ch_q = '{0};
    mon_start();
    wait_acc(1, 200);
    chk("s7_acc", acc_cnt, 1);
    mon_on = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
